uart_word_tx: RTL and testbench

Serial transmitter that takes one 32-bit data-memory word and sends it on a single TX line as four 8N1 UART bytes. It sits directly downstream of the data memory's dump path. A memory-side sequencer presents a word with a start strobe. The block signals busy while sending and pulses done when the last stop bit completes, so the sequencer can advance its word index.

---
 rtl/uart_word_tx_pkg.sv | 22 ++
 rtl/uart_word_tx_baud_tick.sv | 35 +++
 rtl/uart_word_tx.sv | 141 ++++++++++++++
 tb/tb_uart_word_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_word_tx_pkg.sv
// Shared types and constants for the 32-bit word UART transmitter.
// Holds the frame FSM encoding and the baud counter width helper.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int BITS_PER_BYTE  = 8;
   localparam int BYTES_PER_WORD = 4;

   // Width of a counter spanning 0..clks_per_bit-1, never narrower than 1 bit.
   function automatic int baud_cnt_width(input int clks_per_bit);
      int w;
      w = $clog2(clks_per_bit);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/uart_word_tx_baud_tick.sv
// Free-running bit-period counter for the UART word transmitter.
// bit_end marks the last cycle of a bit; bit_pre_end marks the cycle before it.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic bit_end,
   output logic bit_pre_end
);

   localparam int CW = baud_cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_CNT     = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE_LAST_CNT = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] baud_cnt_r;

   // Bit-period counter, restarted whenever a new frame is accepted.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         baud_cnt_r <= '0;
      end else if (baud_cnt_r == LAST_CNT) begin
         baud_cnt_r <= '0;
      end else begin
         baud_cnt_r <= baud_cnt_r + CW'(1);
      end
   end

   assign bit_end     = (baud_cnt_r == LAST_CNT);
   assign bit_pre_end = (baud_cnt_r == PRE_LAST_CNT);

endmodule

// File: rtl/uart_word_tx.sv
// Sends one 32-bit word as four back-to-back 8N1 bytes on txd.
// busy covers the frame; done pulses in the final stop-bit cycle, when a new start is already accepted.
module uart_word_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT   = 434,
   parameter bit MSB_BYTE_FIRST = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] data_in,
   output logic        busy,
   output logic        done,
   output logic        txd
);

   localparam int WORD_W = BITS_PER_BYTE * BYTES_PER_WORD;
   localparam logic [2:0] LAST_BIT  = 3'(BITS_PER_BYTE - 1);
   localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   uart_state_e       state_r, state_next_s;
   logic [WORD_W-1:0] shift_r, shift_next_s;
   logic [2:0]        bit_cnt_r, bit_cnt_next_s;
   logic [1:0]        byte_idx_r, byte_idx_next_s;
   logic              accept_s, bit_end_s, bit_pre_end_s, frame_end_s;
   logic              txd_r, busy_r, done_r;
   logic              txd_next_s, busy_next_s, done_next_s;

   // Byte order on the wire: the low byte of the shift register goes out first.
   function automatic logic [WORD_W-1:0] wire_order(input logic [WORD_W-1:0] w);
      if (MSB_BYTE_FIRST) begin
         return {w[7:0], w[15:8], w[23:16], w[31:24]};
      end else begin
         return w;
      end
   endfunction

   assign accept_s    = (state_r == IDLE) && start;
   // The last stop bit finishes in IDLE so a new start can be taken in the done cycle.
   assign frame_end_s = (state_r == STOP) && (byte_idx_r == LAST_BYTE) && bit_pre_end_s;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk        (clk),
      .rst        (rst),
      .clr        (accept_s),
      .bit_end    (bit_end_s),
      .bit_pre_end(bit_pre_end_s)
   );

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         shift_r    <= '0;
         bit_cnt_r  <= 3'd0;
         byte_idx_r <= 2'd0;
         txd_r      <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         shift_r    <= shift_next_s;
         bit_cnt_r  <= bit_cnt_next_s;
         byte_idx_r <= byte_idx_next_s;
         txd_r      <= txd_next_s;
         busy_r     <= busy_next_s;
         done_r     <= done_next_s;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_next_s    = state_r;
      shift_next_s    = shift_r;
      bit_cnt_next_s  = bit_cnt_r;
      byte_idx_next_s = byte_idx_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s    = START;
               shift_next_s    = wire_order(data_in);
               bit_cnt_next_s  = 3'd0;
               byte_idx_next_s = 2'd0;
            end else begin
               state_next_s = IDLE;
            end
         end
         START: begin
            if (bit_end_s) begin
               state_next_s = DATA;
            end else begin
               state_next_s = START;
            end
         end
         DATA: begin
            if (bit_end_s) begin
               shift_next_s   = shift_r >> 1;
               bit_cnt_next_s = bit_cnt_r + 3'd1;
               state_next_s   = (bit_cnt_r == LAST_BIT) ? STOP : DATA;
            end else begin
               state_next_s = DATA;
            end
         end
         STOP: begin
            if (frame_end_s) begin
               state_next_s = IDLE;
            end else if (bit_end_s) begin
               byte_idx_next_s = byte_idx_r + 2'd1;
               state_next_s    = START;
            end else begin
               state_next_s = STOP;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, taken from the next state so txd lines up with it.
   always_comb begin
      txd_next_s  = 1'b1;
      busy_next_s = (state_next_s != IDLE);
      done_next_s = frame_end_s;
      case (state_next_s)
         IDLE:    txd_next_s = 1'b1;
         START:   txd_next_s = 1'b0;
         DATA:    txd_next_s = shift_next_s[0];
         STOP:    txd_next_s = 1'b1;
         default: txd_next_s = 1'b1;
      endcase
   end

   assign txd  = txd_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: three instances (LSB-first, MSB-first, full-speed baud) checked
// every cycle against a frame-position model, plus literal expectations per scenario.
module tb_uart_word_tx;

   localparam int CPB   = 4;
   localparam int CPB_S = 434;

   logic        clk = 1'b0;
   logic [2:0]  rst_v, start_v, busy_v, done_v, txd_v;
   logic [31:0] data_v [3];

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;

   int          cpb_a [3] = '{CPB, CPB, CPB_S};
   bit          msb_a [3] = '{1'b0, 1'b1, 1'b0};
   int          m_pos [3] = '{0, 0, 0};
   logic [31:0] m_word [3];

   int          done_q [3][$];
   logic [7:0]  dec_q  [2][$];
   int          dec_ph [2] = '{-1, -1};
   logic [7:0]  dec_sh [2];
   int          edge_q [$];
   logic        txd2_prev = 1'b1;
   int          busy_cnt0 = 0;
   int          busy_first0 = -1;

   always #5 clk = ~clk;

   uart_word_tx #(.CLKS_PER_BIT(CPB), .MSB_BYTE_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .data_in(data_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .txd(txd_v[0]));
   uart_word_tx #(.CLKS_PER_BIT(CPB), .MSB_BYTE_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .data_in(data_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .txd(txd_v[1]));
   uart_word_tx #(.CLKS_PER_BIT(CPB_S), .MSB_BYTE_FIRST(1'b0)) dut2 (
      .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .data_in(data_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .txd(txd_v[2]));

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 40)
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Line level at frame position pos (1 = first start-bit cycle, 0 = idle).
   function automatic logic exp_txd(input int pos, input logic [31:0] w, input bit msb, input int cpb);
      int b, byte_n, k, sel;
      if (pos == 0) return 1'b1;
      b      = (pos - 1) / cpb;
      byte_n = b / 10;
      k      = b % 10;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      sel = msb ? 3 - byte_n : byte_n;
      return w[8*sel + k - 1];
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Model: position inside the 40-bit frame; the done cycle counts as idle.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (rst_v[d]) begin
            m_pos[d] <= 0;
         end else if (m_pos[d] == 0 || m_pos[d] == 40 * cpb_a[d]) begin
            if (start_v[d]) begin
               m_pos[d]  <= 1;
               m_word[d] <= data_v[d];
            end else begin
               m_pos[d] <= 0;
            end
         end else begin
            m_pos[d] <= m_pos[d] + 1;
         end
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (cyc >= 2) begin
         for (int d = 0; d < 3; d++) begin
            check32($sformatf("txd[%0d]", d), {31'd0, txd_v[d]},
                    {31'd0, exp_txd(m_pos[d], m_word[d], msb_a[d], cpb_a[d])});
            check32($sformatf("busy[%0d]", d), {31'd0, busy_v[d]},
                    {31'd0, (m_pos[d] > 0 && m_pos[d] < 40 * cpb_a[d])});
            check32($sformatf("done[%0d]", d), {31'd0, done_v[d]},
                    {31'd0, (m_pos[d] == 40 * cpb_a[d])});
            if (done_v[d] === 1'b1) done_q[d].push_back(cyc);
         end
         if (busy_v[0] === 1'b1 && cyc <= 180) begin
            busy_cnt0 = busy_cnt0 + 1;
            if (busy_first0 < 0) busy_first0 = cyc;
         end
      end
   end

   // UART receivers on the two fast instances, sampling mid-bit.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst_v[d]) begin
            dec_ph[d] <= -1;
         end else if (dec_ph[d] < 0) begin
            if (txd_v[d] === 1'b0) dec_ph[d] <= 1;
         end else if (dec_ph[d] == 2 && txd_v[d] !== 1'b0) begin
            dec_ph[d] <= -1;
         end else if (dec_ph[d] == 9 * CPB + CPB / 2) begin
            check32($sformatf("stop_bit[%0d]", d), {31'd0, txd_v[d]}, 32'd1);
            dec_q[d].push_back(dec_sh[d]);
            dec_ph[d] <= -1;
         end else begin
            if (dec_ph[d] % CPB == CPB / 2 && dec_ph[d] > CPB)
               dec_sh[d] <= {txd_v[d], dec_sh[d][7:1]};
            dec_ph[d] <= dec_ph[d] + 1;
         end
      end
   end

   // Transition times on the slow instance's line.
   always @(negedge clk) begin
      if (cyc >= 3) begin
         if (txd_v[2] !== txd2_prev && edge_q.size() < 11) edge_q.push_back(cyc);
         txd2_prev <= txd_v[2];
      end
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic check_bytes(input string nm, input int d, input logic [31:0] w, input bit msb);
      check32({nm, "_count"}, dec_q[d].size(), 32'd4);
      for (int i = 0; i < 4 && i < dec_q[d].size(); i++)
         check32($sformatf("%s_byte%0d", nm, i), {24'd0, dec_q[d][i]},
                 {24'd0, w[8*(msb ? 3 - i : i) +: 8]});
   endtask

   logic [7:0]  b2b_exp [8];
   logic [31:0] w5, w6;
   int          t_done;

   initial begin
      rst_v   = 3'b111;
      start_v = 3'b000;
      for (int d = 0; d < 3; d++) data_v[d] = 32'd0;
      b2b_exp = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

      wait_cyc(2);
      for (int d = 0; d < 3; d++) begin
         check32($sformatf("reset_txd[%0d]", d), {31'd0, txd_v[d]}, 32'd1);
         check32($sformatf("reset_busy[%0d]", d), {31'd0, busy_v[d]}, 32'd0);
         check32($sformatf("reset_done[%0d]", d), {31'd0, done_v[d]}, 32'd0);
      end
      wait_cyc(3);
      rst_v = 3'b000;

      // Single word on both byte orders, and the slow instance with 0x55.
      wait_cyc(10);
      start_v   = 3'b111;
      data_v[0] = 32'hA5C3_0F81;
      data_v[1] = 32'hA5C3_0F81;
      data_v[2] = 32'h0000_0055;
      wait_cyc(11);
      start_v = 3'b000;
      for (int d = 0; d < 3; d++) data_v[d] = $urandom;
      wait_cyc(180);
      check32("t1_done_count", done_q[0].size(), 32'd1);
      if (done_q[0].size() > 0) check32("t1_done_cycle", done_q[0][0], 32'd170);
      check32("t1_busy_first", busy_first0, 32'd11);
      check32("t1_busy_cycles", busy_cnt0, 32'd159);
      check_bytes("t1", 0, 32'hA5C3_0F81, 1'b0);
      check32("t2_b0", dec_q[1].size() > 0 ? {24'd0, dec_q[1][0]} : 32'hFFFF, 32'hA5);
      check_bytes("t2", 1, 32'hA5C3_0F81, 1'b1);
      dec_q[0].delete(); dec_q[1].delete(); done_q[0].delete(); done_q[1].delete();

      // Start while busy is ignored.
      wait_cyc(200);
      start_v[0] = 1'b1; data_v[0] = 32'h1111_1111;
      wait_cyc(201);
      start_v[0] = 1'b0; data_v[0] = $urandom;
      wait_cyc(250);
      start_v[0] = 1'b1; data_v[0] = 32'h2222_2222;
      wait_cyc(251);
      start_v[0] = 1'b0;
      wait_cyc(380);
      check32("t3_done_count", done_q[0].size(), 32'd1);
      if (done_q[0].size() > 0) check32("t3_done_cycle", done_q[0][0], 32'd360);
      check_bytes("t3", 0, 32'h1111_1111, 1'b0);
      dec_q[0].delete(); done_q[0].delete();

      // Back-to-back: second start in the done cycle.
      wait_cyc(400);
      start_v[0] = 1'b1; data_v[0] = 32'h1234_5678;
      wait_cyc(401);
      start_v[0] = 1'b0;
      while (done_v[0] !== 1'b1 && cyc < 600) @(negedge clk);
      check32("t4_first_done_seen", {31'd0, done_v[0]}, 32'd1);
      t_done = cyc;
      start_v[0] = 1'b1; data_v[0] = 32'hDEAD_BEEF;
      @(negedge clk);
      start_v[0] = 1'b0; data_v[0] = $urandom;
      check32("t4_no_gap_txd", {31'd0, txd_v[0]}, 32'd0);
      wait_cyc(760);
      check32("t4_done_count", done_q[0].size(), 32'd2);
      if (done_q[0].size() == 2) begin
         check32("t4_done1_cycle", done_q[0][0], 32'd560);
         check32("t4_done_spacing", done_q[0][1] - done_q[0][0], 32'd160);
      end
      check32("t4_byte_count", dec_q[0].size(), 32'd8);
      for (int i = 0; i < 8 && i < dec_q[0].size(); i++)
         check32($sformatf("t4_byte%0d", i), {24'd0, dec_q[0][i]}, {24'd0, b2b_exp[i]});
      dec_q[0].delete(); done_q[0].delete();

      // Reset mid-frame, then a full word.
      w5 = $urandom;
      w6 = $urandom;
      wait_cyc(800);
      start_v[0] = 1'b1; data_v[0] = w5;
      wait_cyc(801);
      start_v[0] = 1'b0;
      wait_cyc(860);
      rst_v[0] = 1'b1;
      wait_cyc(861);
      rst_v[0] = 1'b0;
      check32("t5_txd_after_rst", {31'd0, txd_v[0]}, 32'd1);
      check32("t5_busy_after_rst", {31'd0, busy_v[0]}, 32'd0);
      wait_cyc(1000);
      check32("t5_no_done", done_q[0].size(), 32'd0);
      dec_q[0].delete();
      start_v[0] = 1'b1; data_v[0] = w6;
      wait_cyc(1001);
      start_v[0] = 1'b0;
      wait_cyc(1170);
      check32("t5_done_count", done_q[0].size(), 32'd1);
      if (done_q[0].size() > 0) check32("t5_done_cycle", done_q[0][0], 32'd1160);
      check_bytes("t5", 0, w6, 1'b0);

      // Random starts, including many while busy, against the model.
      wait_cyc(1200);
      while (cyc < 6000) begin
         for (int d = 0; d < 2; d++) begin
            start_v[d] = ($urandom_range(0, 15) == 0);
            data_v[d]  = $urandom;
         end
         @(negedge clk);
      end
      start_v = 3'b000;

      // Full-speed baud instance: bit width and frame length.
      while (done_q[2].size() == 0 && cyc < 17600) @(negedge clk);
      check32("t6_done_count", done_q[2].size(), 32'd1);
      if (done_q[2].size() > 0) check32("t6_done_cycle", done_q[2][0], 32'd17370);
      check32("t6_edge_count", edge_q.size(), 32'd11);
      if (edge_q.size() > 0) check32("t6_first_edge", edge_q[0], 32'd11);
      for (int i = 0; i + 1 < edge_q.size(); i++)
         check32($sformatf("t6_bit_width%0d", i), edge_q[i+1] - edge_q[i], 32'd434);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
